// File: rtl/alu_rr_arbiter_if.sv
// Purpose: bundles the request, response, ALU-side and status signals of alu_rr_arbiter.
// Ports:   slave = arbiter view (serves requests, drives the ALU), master = surrounding logic view.
// Request fields are packed per requester: operand i at [8i+7:8i], opcode i at [3i+2:3i].
interface alu_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ*3-1:0] req_op;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [8:0]           resp_result;
    logic                 resp_overflow;
    logic                 resp_illegal;

    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic [2:0]           alu_op;
    logic [8:0]           alu_result;
    logic                 alu_overflow;

    logic                 busy;
    logic [CNT_W-1:0]     op_count;

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready, alu_result, alu_overflow,
        output req_ready, resp_valid, resp_id, resp_result, resp_overflow, resp_illegal,
        output alu_a, alu_b, alu_op, busy, op_count
    );

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready, alu_result, alu_overflow,
        input  req_ready, resp_valid, resp_id, resp_result, resp_overflow, resp_illegal,
        input  alu_a, alu_b, alu_op, busy, op_count
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Purpose: shares one registered ALU between NUM_REQ requesters with round-robin grant.
// Latency: request handshake at cycle N -> resp_valid at N+3; one op in flight, grants >= 4 cycles apart.
// Backpressure: resp_ready low holds the response and keeps every req_ready low until accepted.
// Ports: clk, rst_n (synchronous, active-low) plus the alu_rr_arbiter_if slave modport carrying
//        per-requester valid/ready channels, the shared tagged response channel, the ALU drive/return
//        signals, busy and the completed-operation counter.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input logic            clk,
    input logic            rst_n,
    alu_rr_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    // Opcode parked on the ALU whenever no operation is being issued.
    localparam logic [2:0] OP_PARK = 3'b111;

    logic [1:0]       state_q,         state_d;
    logic [ID_W-1:0]  rr_ptr_q,        rr_ptr_d;
    logic             resp_valid_q,    resp_valid_d;
    logic [ID_W-1:0]  resp_id_q,       resp_id_d;
    logic [8:0]       resp_result_q,   resp_result_d;
    logic             resp_overflow_q, resp_overflow_d;
    logic             resp_illegal_q,  resp_illegal_d;
    logic [7:0]       alu_a_q,         alu_a_d;
    logic [7:0]       alu_b_q,         alu_b_d;
    logic [2:0]       alu_op_q,        alu_op_d;
    logic [CNT_W-1:0] op_count_q,      op_count_d;
    // alu_op is parked during ISSUE, so the illegal flag of the issued op is kept aside.
    logic             illegal_q,       illegal_d;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [NUM_REQ-1:0] req_ready;

    // (base + off) mod NUM_REQ; base < NUM_REQ and off < NUM_REQ so one subtraction suffices.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        logic [ID_W:0] s;
        s = {1'b0, base} + (ID_W+1)'(off);
        if (s >= (ID_W+1)'(NUM_REQ)) begin
            s = s - (ID_W+1)'(NUM_REQ);
        end
        return s[ID_W-1:0];
    endfunction

    // Scan from the farthest offset back to rr_ptr so the closest valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        resp_valid_d    = resp_valid_q;
        resp_id_d       = resp_id_q;
        resp_result_d   = resp_result_q;
        resp_overflow_d = resp_overflow_q;
        resp_illegal_d  = resp_illegal_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_op_d        = alu_op_q;
        op_count_d      = op_count_q;
        illegal_d       = illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    alu_a_d   = bus.req_a[grant_id*8 +: 8];
                    alu_b_d   = bus.req_b[grant_id*8 +: 8];
                    alu_op_d  = bus.req_op[grant_id*3 +: 3];
                    illegal_d = (bus.req_op[grant_id*3 +: 3] >= 3'b101);
                    resp_id_d = grant_id;
                    rr_ptr_d  = wrap_add(grant_id, 1);
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The ALU samples alu_* at this edge; park the opcode afterwards.
                alu_op_d = OP_PARK;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                resp_result_d   = bus.alu_result;
                resp_overflow_d = bus.alu_overflow;
                resp_illegal_d  = illegal_q;
                resp_valid_d    = 1'b1;
                state_d         = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_result_q   <= '0;
            resp_overflow_q <= 1'b0;
            resp_illegal_q  <= 1'b0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_op_q        <= OP_PARK;
            op_count_q      <= '0;
            illegal_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_result_q   <= resp_result_d;
            resp_overflow_q <= resp_overflow_d;
            resp_illegal_q  <= resp_illegal_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_op_q        <= alu_op_d;
            op_count_q      <= op_count_d;
            illegal_q       <= illegal_d;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_result   = resp_result_q;
    assign bus.resp_overflow = resp_overflow_q;
    assign bus.resp_illegal  = resp_illegal_q;
    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.op_count      = op_count_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Purpose: directed self-checking bench for alu_rr_arbiter with a registered ALU model.
// Latency: ALU model returns its result one clock after sampling alu_*.
// Backpressure: resp_ready is driven per scenario.
module tb_alu_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

    alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ALU: add reports signed overflow, sub reports borrow, logic ops zero-extend, 101..111 give 0.
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] s;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                return {(a[7] == b[7]) && (s[7] != a[7]), s};
            end
            3'b001: begin
                s = {1'b0, a} - {1'b0, b};
                return {(a < b), s};
            end
            3'b010:  return {2'b00, a & b};
            3'b011:  return {2'b00, a | b};
            3'b100:  return {2'b00, a ^ b};
            default: return 10'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        {bus.alu_overflow, bus.alu_result} <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        bus.req_valid[i]    = v;
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
        bus.req_op[i*3 +: 3] = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
        checks++; if (bus.resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id got %0d exp 0", bus.resp_id); end
        checks++; if (bus.resp_result !== 9'h000) begin errors++; $display("FAIL reset_resp_result got %h exp 000", bus.resp_result); end
        checks++; if (bus.resp_overflow !== 1'b0 || bus.resp_illegal !== 1'b0) begin errors++; $display("FAIL reset_resp_flags got %b%b exp 00", bus.resp_overflow, bus.resp_illegal); end
        checks++; if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00) begin errors++; $display("FAIL reset_alu_ab got %h %h exp 00 00", bus.alu_a, bus.alu_b); end
        checks++; if (bus.alu_op !== 3'b111) begin errors++; $display("FAIL reset_alu_op got %b exp 111", bus.alu_op); end
        checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", bus.op_count); end
    endtask

    task automatic test_add();
        bus.resp_ready = 1'b1;
        set_req(0, 1'b1, 8'd200, 8'd100, 3'b000);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL add_req_ready got %b exp 0001", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_idle_busy got %b exp 0", bus.busy); end
        tick();
        set_req(0, 1'b0, 8'd0, 8'd0, 3'b000);
        #1;
        checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL add_issue_busy_ready got %b %b exp 1 0000", bus.busy, bus.req_ready); end
        checks++; if (bus.alu_a !== 8'd200 || bus.alu_b !== 8'd100 || bus.alu_op !== 3'b000) begin errors++; $display("FAIL add_issue_alu got %h %h %b exp c8 64 000", bus.alu_a, bus.alu_b, bus.alu_op); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL add_issue_resp_valid got %b exp 0", bus.resp_valid); end
        tick();
        checks++; if (bus.alu_op !== 3'b111 || bus.alu_a !== 8'd200) begin errors++; $display("FAIL add_capture_alu got %b %h exp 111 c8", bus.alu_op, bus.alu_a); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL add_capture_resp_valid got %b exp 0", bus.resp_valid); end
        tick();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0) begin errors++; $display("FAIL add_resp_valid_id got %b %0d exp 1 0", bus.resp_valid, bus.resp_id); end
        checks++; if (bus.resp_result !== 9'h12C || bus.resp_overflow !== 1'b0 || bus.resp_illegal !== 1'b0) begin errors++; $display("FAIL add_resp_data got %h %b %b exp 12c 0 0", bus.resp_result, bus.resp_overflow, bus.resp_illegal); end
        checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL add_count_before got %0d exp 0", bus.op_count); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.op_count !== 16'd1 || bus.busy !== 1'b0) begin errors++; $display("FAIL add_after_hs got %b %0d %b exp 0 1 0", bus.resp_valid, bus.op_count, bus.busy); end
    endtask

    task automatic test_sub();
        set_req(2, 1'b1, 8'd5, 8'd10, 3'b001);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL sub_req_ready got %b exp 0100", bus.req_ready); end
        tick();
        set_req(2, 1'b0, 8'd0, 8'd0, 3'b000);
        tick();
        tick();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2) begin errors++; $display("FAIL sub_resp_valid_id got %b %0d exp 1 2", bus.resp_valid, bus.resp_id); end
        checks++; if (bus.resp_result !== 9'h1FB || bus.resp_overflow !== 1'b1) begin errors++; $display("FAIL sub_resp_data got %h %b exp 1fb 1", bus.resp_result, bus.resp_overflow); end
        tick();
        checks++; if (bus.op_count !== 16'd2) begin errors++; $display("FAIL sub_op_count got %0d exp 2", bus.op_count); end
    endtask

    task automatic test_round_robin();
        int         exp_id;
        logic [8:0] exp_res;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        set_req(0, 1'b1, 8'hF0, 8'h3C, 3'b010);
        set_req(1, 1'b1, 8'hF0, 8'h3C, 3'b011);
        set_req(2, 1'b1, 8'hF0, 8'h3C, 3'b100);
        set_req(3, 1'b1, 8'hAA, 8'h0F, 3'b010);
        #1;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % 4;
            case (exp_id)
                0:       exp_res = 9'h030;
                1:       exp_res = 9'h0FC;
                2:       exp_res = 9'h0CC;
                default: exp_res = 9'h00A;
            endcase
            checks++; if (bus.req_ready !== 4'(1 << exp_id)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", g, bus.req_ready, 4'(1 << exp_id)); end
            tick();
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rr_busy_ready%0d got %b exp 0000", g, bus.req_ready); end
            tick();
            tick();
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(exp_id) || bus.resp_result !== exp_res) begin errors++; $display("FAIL rr_resp%0d got %b %0d %h exp 1 %0d %h", g, bus.resp_valid, bus.resp_id, bus.resp_result, exp_id, exp_res); end
            tick();
        end
        bus.req_valid = '0;
        #1;
        checks++; if (bus.op_count !== 16'd5) begin errors++; $display("FAIL rr_op_count got %0d exp 5", bus.op_count); end
    endtask

    task automatic test_illegal();
        set_req(1, 1'b1, 8'hFF, 8'h0F, 3'b110);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL ill_req_ready got %b exp 0010", bus.req_ready); end
        tick();
        set_req(1, 1'b0, 8'd0, 8'd0, 3'b000);
        tick();
        tick();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1) begin errors++; $display("FAIL ill_resp_valid_id got %b %0d exp 1 1", bus.resp_valid, bus.resp_id); end
        checks++; if (bus.resp_result !== 9'h000 || bus.resp_overflow !== 1'b0 || bus.resp_illegal !== 1'b1) begin errors++; $display("FAIL ill_resp_data got %h %b %b exp 000 0 1", bus.resp_result, bus.resp_overflow, bus.resp_illegal); end
        tick();
        checks++; if (bus.op_count !== 16'd6 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL ill_after_hs got %0d %b exp 6 0", bus.op_count, bus.resp_valid); end
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 1'b0;
        set_req(3, 1'b1, 8'd1, 8'd2, 3'b000);
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_req_ready got %b exp 1000", bus.req_ready); end
        tick();
        set_req(3, 1'b0, 8'd0, 8'd0, 3'b000);
        set_req(0, 1'b1, 8'd3, 8'd4, 3'b000);
        set_req(1, 1'b1, 8'd5, 8'd6, 3'b000);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3 || bus.resp_result !== 9'h003) begin errors++; $display("FAIL bp_hold%0d got %b %0d %h exp 1 3 003", c, bus.resp_valid, bus.resp_id, bus.resp_result); end
            checks++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL bp_stall%0d got %b %b exp 0000 1", c, bus.req_ready, bus.busy); end
            if (c < 4) tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.op_count !== 16'd7 || bus.busy !== 1'b0) begin errors++; $display("FAIL bp_accept got %b %0d %b exp 0 7 0", bus.resp_valid, bus.op_count, bus.busy); end
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got %b exp 0001", bus.req_ready); end
        tick();
        set_req(0, 1'b0, 8'd0, 8'd0, 3'b000);
        set_req(1, 1'b0, 8'd0, 8'd0, 3'b000);
        tick();
        tick();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_result !== 9'h007) begin errors++; $display("FAIL bp_second_resp got %b %0d %h exp 1 0 007", bus.resp_valid, bus.resp_id, bus.resp_result); end
        tick();
        checks++; if (bus.op_count !== 16'd8) begin errors++; $display("FAIL bp_op_count got %0d exp 8", bus.op_count); end
    endtask

    task automatic test_reset_mid();
        set_req(2, 1'b1, 8'd9, 8'd1, 3'b000);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_req_ready got %b exp 0100", bus.req_ready); end
        tick();
        set_req(2, 1'b0, 8'd0, 8'd0, 3'b000);
        tick();
        checks++; if (bus.busy !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_capture got %b %b exp 1 0", bus.busy, bus.resp_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_state got %b %b exp 0 0", bus.resp_valid, bus.busy); end
        checks++; if (bus.alu_op !== 3'b111 || bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00) begin errors++; $display("FAIL mid_reset_alu got %b %h %h exp 111 00 00", bus.alu_op, bus.alu_a, bus.alu_b); end
        checks++; if (bus.resp_id !== 2'd0 || bus.resp_result !== 9'h000 || bus.op_count !== 16'd0) begin errors++; $display("FAIL mid_reset_resp got %0d %h %0d exp 0 000 0", bus.resp_id, bus.resp_result, bus.op_count); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_no_resp got %b %b exp 0 0", bus.resp_valid, bus.busy); end
        set_req(0, 1'b1, 8'd1, 8'd1, 3'b000);
        set_req(3, 1'b1, 8'd1, 8'd1, 3'b000);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_ptr got %b exp 0001", bus.req_ready); end
        bus.req_valid = '0;
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_round_robin();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one registered ALU between NUM_REQ requesters using round-robin arbitration. Each requester has its own valid/ready request channel. The block drives the ALU operand/op inputs, waits out the ALU's one-cycle register latency, and captures the result. It then returns the result on a single shared response channel tagged with the requester id. Only one operation is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID_W = $clog2(NUM_REQ) is a derived localparam.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_a  in  NUM_REQ*8  operand A, requester i at [8i+7:8i]
req_b  in  NUM_REQ*8  operand B, same packing
req_op  in  NUM_REQ*3  opcode, requester i at [3i+2:3i]
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  ID_W  index of requester that owns the response
resp_result  out  9  ALU result
resp_overflow  out  1  ALU overflow
resp_illegal  out  1  op was 3'b101..3'b111
alu_a  out  8  to ALU a
alu_b  out  8  to ALU b
alu_op  out  3  to ALU op
alu_result  in  9  from ALU result, valid one cycle after alu_* is sampled
alu_overflow  in  1  from ALU overflow
busy  out  1  high in any state other than IDLE
op_count  out  CNT_W  count of completed response handshakes

Behaviour:
- Reset (sync, rst_n=0 at posedge) sets: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_overflow=0, resp_illegal=0, alu_a=0, alu_b=0, alu_op=3'b111, op_count=0.
- Reset mid-operation discards the in-flight op; no response is produced for it.
- All outputs are registered except req_ready and busy, which decode state/grant combinationally.

State machine: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[grant]=1 in the same cycle; the transfer happens that cycle.
  - At the edge: alu_a/alu_b/alu_op load the granted fields, resp_id=grant, rr_ptr=(grant+1) mod NUM_REQ, state goes to ISSUE.
  - No valid requester: remain in IDLE, req_ready=0.
- ISSUE: alu_* are stable and the ALU samples them at this edge. At the edge: alu_op returns to 3'b111; alu_a/alu_b hold; state goes to CAPTURE.
- CAPTURE: alu_result/alu_overflow correspond to the issued op. At the edge: resp_result, resp_overflow and resp_illegal (issued op >= 3'b101) are registered, resp_valid=1, state goes to RESP.
- RESP: resp_* hold stable while resp_ready=0. On resp_valid & resp_ready: resp_valid=0, op_count+=1 (wraps at 2^CNT_W), state goes to IDLE.
- req_ready is 0 in every state except IDLE.
- Latency:
  - Request handshake at cycle N gives resp_valid=1 at cycle N+3.
  - Minimum spacing between grants is 4 cycles (resp_ready tied high).
- The block does not interpret arithmetic; result and overflow pass through unmodified from the ALU.
- The grant is not sticky. A requester that drops req_valid before it is granted loses nothing, and no ordering is guaranteed beyond round-robin.
- A requester must hold req_* stable while req_valid=1 and req_ready=0.

Test Plan:
- Reset, req0 {a=200,b=100,op=000} -> req_ready[0]=1 that cycle; 3 cycles later resp_valid=1, resp_id=0, resp_result=9'h12C, resp_overflow=0, op_count=1 after handshake.
- req2 {a=5,b=10,op=001} -> resp_result=9'h1FB, resp_overflow=1, resp_id=2.
- All four req_valid held high, resp_ready=1 -> grants in order 0,1,2,3,0, each 4 cycles apart; results match per-requester ops (AND/OR/XOR).
- req1 op=110, a=8'hFF, b=8'h0F -> resp_result=0, resp_overflow=0, resp_illegal=1.
- resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready all 0 despite pending requests, busy=1; grant occurs the cycle after acceptance.
- rst_n=0 for one cycle during CAPTURE -> next cycle all outputs at reset values, no resp_valid, op_count unchanged at 0, rr_ptr=0.
